// File: rtl/alarm_pkg.sv
// Shared types and default constants for the alarm ringing controller.
// The ALARM_BEEP_PATTERN_EN build macro is consumed in alarm_ring_ctrl.sv.
package alarm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RING,
      ST_SNOOZE,
      ST_DONE
   } state_t;

   localparam int DEF_RING_SEC   = 60;
   localparam int DEF_SNOOZE_SEC = 300;
   localparam int DEF_MAX_SNOOZE = 3;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/alarm_ring_ctrl_sec_countdown.sv
// Seconds down-counter: counts 1 Hz ticks after a load and flags the tick that
// takes it from 1 to 0.
module sec_countdown #(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             clear,
   input  logic             tick,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] value,
   output logic             expire
);

   assign expire = tick && (value == WIDTH'(1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else if (clear) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (tick && (value != '0)) begin
         value <= value - WIDTH'(1);
      end
   end

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ringing controller: IDLE/RING/SNOOZE/DONE with snooze limit and auto-stop.
// Define ALARM_BEEP_PATTERN_EN for a buzzer that toggles each second while ringing.
module alarm_ring_ctrl
   import alarm_pkg::*;
#(
   parameter int RING_SEC   = DEF_RING_SEC,
   parameter int SNOOZE_SEC = DEF_SNOOZE_SEC,
   parameter int MAX_SNOOZE = DEF_MAX_SNOOZE
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1hz,
   input  logic       match,
   input  logic       alarm_en,
   input  logic       snooze_btn,
   input  logic       stop_btn,
   output logic       buzzer,
   output logic       ringing,
   output logic       snoozing,
   output logic [2:0] snooze_cnt,
   output logic       auto_rst
);

   localparam int TW = $clog2(max_int(RING_SEC, SNOOZE_SEC) + 1);
   localparam logic [TW-1:0] RING_LD   = TW'(RING_SEC);
   localparam logic [TW-1:0] SNOOZE_LD = TW'(SNOOZE_SEC);
   localparam logic [2:0]    MAX_CNT   = 3'(MAX_SNOOZE);

   state_t          state;
   logic            t_load;
   logic            t_clear;
   logic [TW-1:0]   t_val;
   logic [TW-1:0]   t_value;
   logic            t_expire;
   logic            snooze_ok;

   // Only counting below the limit keeps snooze_cnt saturated, never wrapped.
   assign snooze_ok = snooze_btn && (snooze_cnt < MAX_CNT);

   // Timer control is decoded combinationally so a load lands on the same
   // edge as the state change and the Nth tick after entry is the expiry.
   // NOTE: every always_comb output gets a default first to avoid latches.
   always_comb begin
      t_load  = 1'b0;
      t_clear = 1'b0;
      t_val   = RING_LD;
      if (!alarm_en) begin
         t_clear = 1'b1;
      end else begin
         unique case (state)
            ST_IDLE:   t_load = match;
            ST_RING: begin
               if (stop_btn || t_expire) begin
                  t_clear = 1'b1;
               end else if (snooze_ok) begin
                  t_load = 1'b1;
                  t_val  = SNOOZE_LD;
               end
            end
            ST_SNOOZE: begin
               if (stop_btn)      t_clear = 1'b1;
               else if (t_expire) t_load  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   sec_countdown #(.WIDTH(TW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (t_load),
      .clear    (t_clear),
      .tick     (tick_1hz),
      .load_val (t_val),
      .value    (t_value),
      .expire   (t_expire)
   );

   // NOTE: every register here is reset asynchronously so outputs drop the
   // instant rst_n falls, not at the next clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         snooze_cnt <= '0;
         buzzer     <= 1'b0;
         ringing    <= 1'b0;
         snoozing   <= 1'b0;
         auto_rst   <= 1'b0;
      end else begin
         auto_rst <= 1'b0;
         if (!alarm_en) begin
            auto_rst   <= (state == ST_RING) || (state == ST_SNOOZE);
            state      <= ST_IDLE;
            snooze_cnt <= '0;
            buzzer     <= 1'b0;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  if (match) begin
                     state      <= ST_RING;
                     snooze_cnt <= '0;
                     buzzer     <= 1'b1;
                     ringing    <= 1'b1;
                  end
               end
               ST_RING: begin
                  if (stop_btn || t_expire) begin
                     state    <= ST_DONE;
                     auto_rst <= 1'b1;
                     buzzer   <= 1'b0;
                     ringing  <= 1'b0;
                  end else if (snooze_ok) begin
                     state      <= ST_SNOOZE;
                     snooze_cnt <= snooze_cnt + 3'd1;
                     auto_rst   <= 1'b1;
                     buzzer     <= 1'b0;
                     ringing    <= 1'b0;
                     snoozing   <= 1'b1;
                  end else begin
`ifdef ALARM_BEEP_PATTERN_EN
                     if (tick_1hz) buzzer <= ~buzzer;
`endif
                  end
               end
               ST_SNOOZE: begin
                  if (stop_btn) begin
                     state    <= ST_DONE;
                     snoozing <= 1'b0;
                  end else if (t_expire) begin
                     state    <= ST_RING;
                     buzzer   <= 1'b1;
                     ringing  <= 1'b1;
                     snoozing <= 1'b0;
                  end
               end
               ST_DONE: begin
                  // Hold until the comparator releases so the same second cannot retrigger.
                  if (!match) state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl with RING_SEC=4, SNOOZE_SEC=3, MAX_SNOOZE=2.
// Buzzer expectations follow ALARM_BEEP_PATTERN_EN when it is defined.
module tb_alarm_ring_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick_1hz = 1'b0;
   logic       match = 1'b0;
   logic       alarm_en = 1'b0;
   logic       snooze_btn = 1'b0;
   logic       stop_btn = 1'b0;
   logic       buzzer;
   logic       ringing;
   logic       snoozing;
   logic [2:0] snooze_cnt;
   logic       auto_rst;

   int compared   = 0;
   int mismatched = 0;

   alarm_ring_ctrl #(
      .RING_SEC   (4),
      .SNOOZE_SEC (3),
      .MAX_SNOOZE (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_1hz   (tick_1hz),
      .match      (match),
      .alarm_en   (alarm_en),
      .snooze_btn (snooze_btn),
      .stop_btn   (stop_btn),
      .buzzer     (buzzer),
      .ringing    (ringing),
      .snoozing   (snoozing),
      .snooze_cnt (snooze_cnt),
      .auto_rst   (auto_rst)
   );

   always #5 clk = ~clk;

   // Observed vector layout: {buzzer, ringing, snoozing, auto_rst, snooze_cnt}
   function automatic logic [6:0] obs();
      return {buzzer, ringing, snoozing, auto_rst, snooze_cnt};
   endfunction

   function automatic logic [6:0] ev(input logic b, input logic r, input logic s,
                                     input logic a, input logic [2:0] c);
      return {b, r, s, a, c};
   endfunction

   // Expected buzzer after n ticks spent in RING since entry.
   function automatic logic beep(input int n);
`ifdef ALARM_BEEP_PATTERN_EN
      return (n % 2) == 0;
`else
      return 1'b1;
`endif
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_once();
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
      cyc();
   endtask

   task automatic go_idle();
      alarm_en   = 1'b0;
      match      = 1'b0;
      snooze_btn = 1'b0;
      stop_btn   = 1'b0;
      cyc();
      cyc();
      alarm_en = 1'b1;
   endtask

   task automatic start_ring();
      match = 1'b1;
      cyc();
      match = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      compared++;
      if (obs() !== 7'b0) begin
         mismatched++;
         $display("FAIL reset_state: got %b expected %b", obs(), 7'b0);
      end
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();
      compared++;
      if (obs() !== 7'b0) begin
         mismatched++;
         $display("FAIL post_reset_idle: got %b expected %b", obs(), 7'b0);
      end
   endtask

   task automatic test_ring_expire();
      go_idle();
      match = 1'b1;
      cyc();
      compared++;
      if (obs() !== ev(1, 1, 0, 0, 0)) begin
         mismatched++;
         $display("FAIL ring_entry: got %b expected %b", obs(), ev(1, 1, 0, 0, 0));
      end
      for (int i = 1; i <= 3; i++) begin
         tick_once();
         compared++;
         if (obs() !== ev(beep(i), 1, 0, 0, 0)) begin
            mismatched++;
            $display("FAIL ring_tick%0d: got %b expected %b", i, obs(), ev(beep(i), 1, 0, 0, 0));
         end
      end
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
      compared++;
      if (obs() !== ev(0, 0, 0, 1, 0)) begin
         mismatched++;
         $display("FAIL expire_done: got %b expected %b", obs(), ev(0, 0, 0, 1, 0));
      end
      cyc();
      compared++;
      if (obs() !== ev(0, 0, 0, 0, 0)) begin
         mismatched++;
         $display("FAIL expire_auto_rst_single: got %b expected %b", obs(), ev(0, 0, 0, 0, 0));
      end
      repeat (3) cyc();
      compared++;
      if (obs() !== ev(0, 0, 0, 0, 0)) begin
         mismatched++;
         $display("FAIL done_no_retrigger: got %b expected %b", obs(), ev(0, 0, 0, 0, 0));
      end
      match = 1'b0;
      cyc();
      match = 1'b1;
      cyc();
      match = 1'b0;
      compared++;
      if (obs() !== ev(1, 1, 0, 0, 0)) begin
         mismatched++;
         $display("FAIL retrigger_after_release: got %b expected %b", obs(), ev(1, 1, 0, 0, 0));
      end
   endtask

   task automatic test_snooze();
      go_idle();
      start_ring();
      for (int k = 1; k <= 2; k++) begin
         snooze_btn = 1'b1;
         cyc();
         snooze_btn = 1'b0;
         compared++;
         if (obs() !== ev(0, 0, 1, 1, 3'(k))) begin
            mismatched++;
            $display("FAIL snooze_enter%0d: got %b expected %b", k, obs(), ev(0, 0, 1, 1, 3'(k)));
         end
         tick_once();
         tick_once();
         compared++;
         if (obs() !== ev(0, 0, 1, 0, 3'(k))) begin
            mismatched++;
            $display("FAIL snooze_wait%0d: got %b expected %b", k, obs(), ev(0, 0, 1, 0, 3'(k)));
         end
         tick_1hz = 1'b1;
         cyc();
         tick_1hz = 1'b0;
         compared++;
         if (obs() !== ev(1, 1, 0, 0, 3'(k))) begin
            mismatched++;
            $display("FAIL re_ring%0d: got %b expected %b", k, obs(), ev(1, 1, 0, 0, 3'(k)));
         end
      end
      snooze_btn = 1'b1;
      cyc();
      snooze_btn = 1'b0;
      compared++;
      if (obs() !== ev(1, 1, 0, 0, 2)) begin
         mismatched++;
         $display("FAIL snooze_limit_ignored: got %b expected %b", obs(), ev(1, 1, 0, 0, 2));
      end
      repeat (3) tick_once();
      compared++;
      if (obs() !== ev(beep(3), 1, 0, 0, 2)) begin
         mismatched++;
         $display("FAIL limit_timer_unchanged: got %b expected %b", obs(), ev(beep(3), 1, 0, 0, 2));
      end
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
      compared++;
      if (obs() !== ev(0, 0, 0, 1, 2)) begin
         mismatched++;
         $display("FAIL limit_expire: got %b expected %b", obs(), ev(0, 0, 0, 1, 2));
      end
   endtask

   task automatic test_stop_wins();
      go_idle();
      start_ring();
      snooze_btn = 1'b1;
      cyc();
      snooze_btn = 1'b0;
      tick_once();
      tick_once();
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
      snooze_btn = 1'b1;
      stop_btn   = 1'b1;
      cyc();
      snooze_btn = 1'b0;
      stop_btn   = 1'b0;
      compared++;
      if (obs() !== ev(0, 0, 0, 1, 1)) begin
         mismatched++;
         $display("FAIL stop_wins: got %b expected %b", obs(), ev(0, 0, 0, 1, 1));
      end
      cyc();
      compared++;
      if (obs() !== ev(0, 0, 0, 0, 1)) begin
         mismatched++;
         $display("FAIL stop_single_auto_rst: got %b expected %b", obs(), ev(0, 0, 0, 0, 1));
      end
      start_ring();
      compared++;
      if (obs() !== ev(1, 1, 0, 0, 0)) begin
         mismatched++;
         $display("FAIL new_event_cnt_clear: got %b expected %b", obs(), ev(1, 1, 0, 0, 0));
      end
      stop_btn = 1'b1;
      cyc();
      stop_btn = 1'b0;
      compared++;
      if (obs() !== ev(0, 0, 0, 1, 0)) begin
         mismatched++;
         $display("FAIL stop_only: got %b expected %b", obs(), ev(0, 0, 0, 1, 0));
      end
   endtask

   task automatic test_en_drop();
      go_idle();
      start_ring();
      snooze_btn = 1'b1;
      cyc();
      snooze_btn = 1'b0;
      alarm_en = 1'b0;
      cyc();
      compared++;
      if (obs() !== ev(0, 0, 0, 1, 0)) begin
         mismatched++;
         $display("FAIL en_drop_idle: got %b expected %b", obs(), ev(0, 0, 0, 1, 0));
      end
      alarm_en = 1'b1;
      cyc();
      compared++;
      if (obs() !== ev(0, 0, 0, 0, 0)) begin
         mismatched++;
         $display("FAIL en_drop_quiet: got %b expected %b", obs(), ev(0, 0, 0, 0, 0));
      end
      start_ring();
      compared++;
      if (obs() !== ev(1, 1, 0, 0, 0)) begin
         mismatched++;
         $display("FAIL en_drop_rearm: got %b expected %b", obs(), ev(1, 1, 0, 0, 0));
      end
   endtask

   task automatic test_reset_mid_ring();
      go_idle();
      start_ring();
      tick_once();
      #2;
      rst_n = 1'b0;
      #1;
      compared++;
      if (obs() !== 7'b0) begin
         mismatched++;
         $display("FAIL reset_immediate: got %b expected %b", obs(), 7'b0);
      end
      cyc();
      cyc();
      rst_n = 1'b1;
      repeat (3) cyc();
      compared++;
      if (obs() !== 7'b0) begin
         mismatched++;
         $display("FAIL reset_no_resume: got %b expected %b", obs(), 7'b0);
      end
      start_ring();
      compared++;
      if (obs() !== ev(1, 1, 0, 0, 0)) begin
         mismatched++;
         $display("FAIL reset_new_match: got %b expected %b", obs(), ev(1, 1, 0, 0, 0));
      end
   endtask

   initial begin
      test_reset();
      test_ring_expire();
      test_snooze();
      test_stop_wins();
      test_en_drop();
      test_reset_mid_ring();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/alarm_ring_ctrl.md
ALARM_RING_CTRL -- requirements
Module: alarm_ring_ctrl

Interface
REQ-001 SHALL have parameter RING_SEC, default 60, seconds of ringing before auto-stop (1..255).
REQ-002 SHALL have parameter SNOOZE_SEC, default 300, seconds of snooze before re-ring (1..1023).
REQ-003 SHALL have parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event (0..7).
REQ-004 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port tick_1hz  input  1  one-clk pulse per second, clk-synchronous.
REQ-007 SHALL have port match  input  1  alarm-time comparator hit (level).
REQ-008 SHALL have port alarm_en  input  1  alarm armed switch (level).
REQ-009 SHALL have port snooze_btn  input  1  debounced one-clk pulse.
REQ-010 SHALL have port stop_btn  input  1  debounced one-clk pulse.
REQ-011 SHALL have port buzzer  output  1  buzzer drive.
REQ-012 SHALL have port ringing  output  1  high in RING.
REQ-013 SHALL have port snoozing  output  1  high in SNOOZE.
REQ-014 SHALL have port snooze_cnt  output  3  snoozes used in current event.
REQ-015 SHALL have port auto_rst  output  1  one-clk pulse clearing comparator latch.

Function
REQ-016 SHALL implement FSM states IDLE, RING, SNOOZE, DONE; all outputs registered.
REQ-017 IDLE: match=1 and alarm_en=1 -> RING, load timer with RING_SEC, snooze_cnt=0.
REQ-018 Timer SHALL decrement only on tick_1hz; expiry = tick_1hz while timer==1, i.e. Nth tick after load.
REQ-019 RING: stop_btn -> DONE; timer expiry -> DONE; both SHALL pulse auto_rst on the transition cycle.
REQ-020 RING: snooze_btn with snooze_cnt<MAX_SNOOZE -> SNOOZE, snooze_cnt+1, load SNOOZE_SEC, pulse auto_rst.
REQ-021 RING: snooze_btn with snooze_cnt==MAX_SNOOZE SHALL be ignored (remain RING, timer unchanged).
REQ-022 stop_btn and snooze_btn same cycle: stop wins.
REQ-023 SNOOZE: timer expiry -> RING, reload RING_SEC, snooze_cnt held; match ignored; stop_btn -> DONE.
REQ-024 DONE: -> IDLE when match=0; prevents retrigger within the matched second.
REQ-025 alarm_en=0 in any state -> IDLE next cycle, snooze_cnt=0, buzzer=0, auto_rst pulse if leaving RING/SNOOZE.
REQ-026 buzzer SHALL be 0 outside RING; ringing/snoozing exactly one-hot or both 0.
REQ-027 snooze_cnt SHALL saturate at MAX_SNOOZE, never wrap; timer width = clog2(max(RING_SEC,SNOOZE_SEC)+1).

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, timer=0, snooze_cnt=0, buzzer=0, ringing=0, snoozing=0, auto_rst=0.
REQ-029 Reset deassertion mid-alarm SHALL NOT resume ringing until a new match in IDLE.

Configuration
REQ-030 With ALARM_BEEP_PATTERN_EN defined, buzzer SHALL be 1 on RING entry and toggle on every tick_1hz in RING.
REQ-031 Without ALARM_BEEP_PATTERN_EN, buzzer SHALL equal ringing (steady tone).

Structure
REQ-032 Package alarm_pkg SHALL hold the state enum and default-parameter constants.
REQ-033 Timer SHALL be sub-module sec_countdown (load, value, tick, expire outputs).

Verification (RING_SEC=4, SNOOZE_SEC=3, MAX_SNOOZE=2)
REQ-034 match=1, alarm_en=1, no buttons -> ringing 1 cycle later; 4th tick -> DONE, auto_rst one pulse, ringing=0.
REQ-035 Ring, snooze_btn -> snoozing=1, snooze_cnt=1; 3rd tick -> ringing=1; repeat -> cnt=2; third snooze_btn ignored.
REQ-036 snooze_btn+stop_btn same cycle in RING -> DONE, snooze_cnt unchanged, single auto_rst.
REQ-037 alarm_en dropped during SNOOZE -> IDLE next cycle, snooze_cnt=0; match held high in DONE -> no retrigger until match=0.
REQ-038 rst_n asserted mid-RING off-edge -> outputs 0 immediately; pattern macro on -> buzzer toggles 1,0,1 on ticks.
